axis_pattern_gen: RTL
=====================

Name: axis_pattern_gen

Overview:
Parametrised AXI-Stream master that generates packetised test traffic with tlast framing, a configurable inter-packet gap and a selectable payload pattern (incrementing counter or LFSR). It replaces the fixed single-pattern producer used in the stream bring-up top and drives any AXI-Stream slave (FIFO, width converter, checker). It also reports a running count of completed packets for bench and ILA visibility.

Parameters:
DATA_WIDTH, 8, tdata width in bits; MODE 1 is legal only for 8, 16 or 32.
PKT_LEN, 4, beats per packet; must be >= 1.
GAP_CYCLES, 2, idle cycles (tvalid=0) after each packet; must be >= 0.
MODE, 0, payload pattern: 0 = incrementing counter, 1 = Fibonacci LFSR.
LFSR_SEED, 1, initial LFSR value; must be nonzero.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
enable  in  1  starts packet generation; sampled only in IDLE and at packet boundaries.
m_tdata  out  DATA_WIDTH  payload.
m_tvalid  out  1  beat valid.
m_tready  in  1  slave ready.
m_tlast  out  1  high on the final beat of each packet.
pkt_count  out  16  number of completed packets; wraps from 0xFFFF to 0.
busy  out  1  high in SEND or GAP.

Behaviour:
- Reset (async assert, clears immediately):
  - m_tvalid=0, m_tlast=0, m_tdata=0, pkt_count=0, busy=0.
  - State IDLE; beat counter 0.
  - Pattern register = 0 for MODE 0, LFSR_SEED for MODE 1.
- Reset mid-packet abandons the partial packet; no completion is counted.
- States: IDLE, SEND, GAP.
- IDLE:
  - m_tvalid=0.
  - enable=1 sampled at an edge -> SEND; first beat valid in the following cycle (1-cycle latency).
- SEND:
  - m_tvalid=1. m_tdata = pattern register. m_tlast = (beat counter == PKT_LEN-1).
  - Transfer occurs on m_tvalid & m_tready at the clock edge.
  - On a transfer, the pattern advances and the beat counter increments.
  - With no transfer, m_tdata, m_tlast and m_tvalid hold stable. tvalid never drops once raised.
- Last-beat transfer:
  - Beat counter clears to 0 and pkt_count increments.
  - GAP_CYCLES > 0 -> GAP.
  - GAP_CYCLES = 0 and enable=1 -> stay in SEND; first beat of the next packet follows with no bubble.
  - GAP_CYCLES = 0 and enable=0 -> IDLE.
- GAP:
  - m_tvalid=0 for exactly GAP_CYCLES cycles.
  - Then enable=1 -> SEND, enable=0 -> IDLE.
- enable deasserted mid-packet: the packet always completes; packets are never truncated.
- Pattern continuity: the pattern is not reset between packets.
  - MODE 0: next = current + 1 mod 2^DATA_WIDTH.
  - MODE 1: next = {cur[W-2:0], ^(cur & TAPS)}.
    - TAPS = 0xB8 for W=8, 0xD008 for W=16, 0x80200003 for W=32.
- m_tready while m_tvalid=0: no effect.
- PKT_LEN=1: m_tlast is high on every beat.
- pkt_count is registered; it updates in the cycle after the last-beat transfer edge.
- busy = (state != IDLE).

Test Plan:
1. Defaults, m_tready=1, enable pulsed 1 cycle:
   - m_tdata 00,01,02,03 on consecutive cycles, m_tlast on 03, pkt_count 0 -> 1.
   - Then 2 cycles with tvalid=0, then IDLE.
2. Defaults, enable held high, m_tready=1:
   - Packets 00-03, gap 2, 04-07, gap 2, 08-0B.
   - tlast on 03, 07, 0B; pkt_count reaches 3.
3. Backpressure: m_tready=0 for 3 cycles while 02 is presented:
   - m_tdata=02 and m_tvalid=1 held stable throughout.
   - 03 follows one cycle after tready rises; packet still 4 beats.
4. MODE=1, DATA_WIDTH=8, LFSR_SEED=1, enable held, m_tready=1:
   - Beats 01,02,04,08 (tlast on 08), then after the gap 11,23.
5. PKT_LEN=1, GAP_CYCLES=0, enable held, m_tready=1:
   - tvalid and tlast high every cycle, tdata 00,01,02,...
   - pkt_count increments every cycle.
   - enable dropped -> tvalid low after the current beat transfers.
6. enable dropped after beat 01:
   - Beats 02,03 still sent, then gap, then IDLE.
   - rst asserted during beat 02 of a later run: tvalid=0 and pkt_count=0 immediately; next run restarts at tdata 00.

Source files
------------

// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen
//   AXI-Stream master that emits packets of PKT_LEN beats framed by tlast.
//   Each packet is followed by GAP_CYCLES idle cycles. The payload is an
//   incrementing counter (MODE 0) or a Fibonacci LFSR (MODE 1). The pattern
//   carries on from one packet to the next.
//
//   State table:
//     IDLE | no traffic; waits for enable
//     SEND | tvalid high; presents the pattern register, one beat per transfer
//     GAP  | tvalid low for GAP_CYCLES cycles after a packet
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   enable     start request, sampled in IDLE and at packet boundaries
//   m_tdata    payload beat
//   m_tvalid   beat valid
//   m_tready   slave ready
//   m_tlast    final beat of a packet
//   pkt_count  completed packets, wraps at 16 bits
//   busy       high in SEND or GAP
module axis_pattern_gen #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    PKT_LEN    = 4,
    parameter int                    GAP_CYCLES = 2,
    parameter int                    MODE       = 0,
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = DATA_WIDTH'(1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [15:0]           pkt_count,
    output logic                  busy
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
    // GAP is entered with GAP_CYCLES-1 loaded and left when the counter is
    // zero, which gives exactly GAP_CYCLES idle cycles.
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [31:0] TAPS_32 = (DATA_WIDTH == 8)  ? 32'h0000_00B8 :
                                      (DATA_WIDTH == 16) ? 32'h0000_D008 :
                                                           32'h8020_0003;
    localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(TAPS_32);

    localparam logic [DATA_WIDTH-1:0] PATTERN_INIT = (MODE == 1) ? LFSR_SEED : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [DATA_WIDTH-1:0]   pattern;
    logic [DATA_WIDTH-1:0]   pattern_next;
    logic                    xfer;
    logic                    at_last;

    assign xfer    = (state == S_SEND) && m_tready;
    assign at_last = (beat_cnt == LAST_BEAT);

    always_comb begin
        pattern_next = pattern + DATA_WIDTH'(1);
        if (MODE == 1) begin
            pattern_next = {pattern[DATA_WIDTH-2:0], ^(pattern & TAPS)};
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    next_state = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer && at_last) begin
                    if (GAP_CYCLES > 0) begin
                        next_state = S_GAP;
                    end else if (!enable) begin
                        next_state = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    next_state = enable ? S_SEND : S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            pattern   <= PATTERN_INIT;
            pkt_count <= 16'd0;
        end else begin
            state <= next_state;
            if (xfer) begin
                pattern <= pattern_next;
                if (at_last) begin
                    beat_cnt  <= '0;
                    pkt_count <= pkt_count + 16'd1;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end
            if (state == S_SEND && next_state == S_GAP) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == S_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // Outputs decode straight from registered state, so they hold stable
    // under backpressure and clear the moment reset asserts.
    assign m_tvalid = (state == S_SEND);
    assign m_tdata  = m_tvalid ? pattern : '0;
    assign m_tlast  = m_tvalid && at_last;
    assign busy     = (state != S_IDLE);

endmodule
